// File: rtl/divider_pkg.sv
// Shared arithmetic package: sequential-ALU state encoding and width helpers.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_e;

    localparam int unsigned DEFAULT_BITS = 8;

    // Down-counter width able to hold the value BITS.
    function automatic int unsigned div_count_w(input int unsigned bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/divider_if.sv
// Start/finished handshake and operand/result bus of the sequential divider.
interface divider_if #(
    parameter int unsigned BITS = 8
);
    logic            i_start;
    logic [BITS-1:0] i_dividend;
    logic [BITS-1:0] i_divisor;
    logic            o_busy;
    logic            o_finished;
    logic            o_error;
    logic [BITS-1:0] o_quotient;
    logic [BITS-1:0] o_remainder;

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_busy, o_finished, o_error, o_quotient, o_remainder
    );

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_busy, o_finished, o_error, o_quotient, o_remainder
    );
endinterface

// File: rtl/divider_adder.sv
// Plain unsigned ripple adder with carry out, reused for the trial subtraction.
module divider_adder #(
    parameter int unsigned BITS = 9
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic [BITS-1:0] o_sum,
    output logic            o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock by shift-subtract.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic     i_clock,
    input  logic     i_reset_n,
    divider_if.slave bus
);

    localparam int unsigned W1 = BITS + 1;
    localparam int unsigned CW = div_count_w(BITS);

    arith_state_e    state_q, state_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] quo_q, quo_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W1-1:0]   ndiv_q, ndiv_d;
    logic            busy_q, busy_d;
    logic            finished_q, finished_d;
    logic            error_q, error_d;
    logic [BITS-1:0] quotient_q, quotient_d;
    logic [BITS-1:0] remainder_q, remainder_d;

    logic [W1-1:0]   shifted;
    logic [W1-1:0]   trial;
    logic            carry_unused;

    assign shifted = {rem_q, quo_q[BITS-1]};

    // trial = shifted - divisor; trial[BITS] set means the subtraction borrowed.
    divider_adder #(.BITS(W1)) u_trial (
        .i_a     (shifted),
        .i_b     (ndiv_q),
        .o_sum   (trial),
        .o_carry (carry_unused)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            count_q     <= '0;
            ndiv_q      <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            count_q     <= count_d;
            ndiv_q      <= ndiv_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        count_d     = count_q;
        ndiv_d      = ndiv_q;
        busy_d      = busy_q;
        finished_d  = 1'b0;
        error_d     = error_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d = RUN;
                    rem_d   = '0;
                    quo_d   = bus.i_dividend;
                    count_d = CW'(BITS);
                    ndiv_d  = W1'(~{1'b0, bus.i_divisor}) + W1'(1);
                    error_d = (bus.i_divisor == '0);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (count_q != '0) begin
                    rem_d   = trial[BITS] ? shifted[BITS-1:0] : trial[BITS-1:0];
                    quo_d   = {quo_q[BITS-2:0], ~trial[BITS]};
                    count_d = count_q - CW'(1);
                end else begin
                    // All bits resolved: publish results for exactly one DONE cycle.
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    finished_d  = 1'b1;
                    quotient_d  = quo_q;
                    remainder_d = rem_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_finished  = finished_q;
    assign bus.o_error     = error_q;
    assign bus.o_quotient  = quotient_q;
    assign bus.o_remainder = remainder_q;

endmodule
